// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } lsu_state_e;

  function automatic logic access_ok(input logic [2:0] size, input logic [1:0] alo);
    case (size)
      SZ_B, SZ_BU: access_ok = 1'b1;
      SZ_H, SZ_HU: access_ok = ~alo[0];
      SZ_W:        access_ok = (alo == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] alo);
    case (size)
      SZ_B, SZ_BU: byte_en = 4'b0001 << alo;
      SZ_H, SZ_HU: byte_en = alo[1] ? 4'b1100 : 4'b0011;
      default:     byte_en = 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every enabled lane already holds the right bytes.
  function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      SZ_B, SZ_BU: lane_data = {4{wd[7:0]}};
      SZ_H, SZ_HU: lane_data = {2{wd[15:0]}};
      default:     lane_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/halfword of a memory word and sign/zero-extends it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_alo,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_alo, 3'b000} +: 8];
    w_half = i_alo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_B:    o_data = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_data = {24'd0, w_byte};
      SZ_H:    o_data = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Cpu data port to word memory bridge with req/ack handshake, lane steering and load extension.
// Optional LSU_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYC cycles without dm_ack.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemReq,
  input  logic              MemWE,
  input  logic [2:0]        MemSize,
  input  logic [31:0]       MemA,
  input  logic [31:0]       MemWD,
  output logic [31:0]       MemRD,
  output logic              Stall,
  output logic              MemErr,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  lsu_state_e        r_state;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd;
  logic              r_err;
  logic [2:0]        r_size;
  logic [1:0]        r_alo;
  logic [31:0]       w_ext;
  logic              w_ok;
  logic              w_unused;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TCNT_W-1:0] r_tcnt;
  logic              w_expired;
  assign w_expired = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
  assign w_unused  = ^MemA[31:ADDR_W+2];
`else
  assign w_unused  = ^MemA[31:ADDR_W+2] ^ (TIMEOUT_CYC == 0);
`endif

  assign w_ok = access_ok(MemSize, MemA[1:0]);

  lsu_load_extend u_load_extend (
    .i_rdata (dm_rdata),
    .i_alo   (r_alo),
    .i_size  (r_size),
    .o_data  (w_ext)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_alo   <= '0;
`ifdef LSU_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (MemReq) begin
            if (w_ok) begin
              r_req   <= 1'b1;
              r_we    <= MemWE;
              r_be    <= byte_en(MemSize, MemA[1:0]);
              r_addr  <= MemA[ADDR_W+1:2];
              r_wdata <= lane_data(MemSize, MemWD);
              r_size  <= MemSize;
              r_alo   <= MemA[1:0];
`ifdef LSU_TIMEOUT_EN
              r_tcnt  <= '0;
`endif
              r_state <= ACCESS;
            end else begin
              r_err   <= 1'b1;
              r_state <= ERR;
            end
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rd <= w_ext;
            r_state <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (w_expired) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ERR;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        DONE: r_state <= IDLE;
        ERR: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Stall    = ((r_state == IDLE) && MemReq) || (r_state == ACCESS);
  assign MemRD    = r_rd;
  assign MemErr   = r_err;
  assign dm_req   = r_req;
  assign dm_we    = r_we;
  assign dm_be    = r_be;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level memory model, random and directed accesses.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MemReq = 1'b0;
  logic        MemWE = 1'b0;
  logic [2:0]  MemSize = 3'd0;
  logic [31:0] MemA = '0;
  logic [31:0] MemWD = '0;
  logic [31:0] MemRD;
  logic        Stall;
  logic        MemErr;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata = '0;
  logic        dm_ack = 1'b0;

  load_store_unit #(.ADDR_W(10), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET), .MemReq(MemReq), .MemWE(MemWE), .MemSize(MemSize),
    .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD), .Stall(Stall), .MemErr(MemErr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  initial forever #5 CLK = ~CLK;

  logic [31:0] dm_mem  [0:1023];
  logic [7:0]  ref_mem [0:4095];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_rd = '0;

  // Data memory: acks dm_req after ack_delay extra cycles, writes by byte enable.
  initial begin
    forever begin
      @(negedge CLK);
      dm_ack = 1'b0;
      if (dm_req) begin
        if (wait_cnt >= ack_delay) begin
          dm_ack = 1'b1;
          wait_cnt = 0;
          if (dm_we) begin
            dm_rdata = $urandom;
            for (int i = 0; i < 4; i++)
              if (dm_be[i]) dm_mem[dm_addr][8*i +: 8] = dm_wdata[8*i +: 8];
          end else begin
            dm_rdata = dm_mem[dm_addr];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (n != 0) && ((int'(a[1:0]) % n) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int base = int'(a[11:0]);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
    if ((sz == 3'b000 || sz == 3'b001) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int dly);
    int n = nbytes(sz);
    int ia = int'(a[1:0]);
    int cyc = 0;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    for (int i = 0; i < 4; i++) begin
      ebe[i] = (i >= ia) && (i < ia + n);
      ewd[8*i +: 8] = (n == 0) ? 8'h00 : wd[8*(i % n) +: 8];
    end
    ack_delay = dly;
    @(negedge CLK);
    MemReq = 1'b1; MemWE = we; MemSize = sz; MemA = a; MemWD = wd;
    #1 check("stall_on_req", Stall, 1);
    @(posedge CLK); #1;
    if (!legal(sz, a)) begin
      check("err_no_req", dm_req, 0);
      check("err_pulse", MemErr, 1);
      check("err_stall", Stall, 0);
      @(negedge CLK); MemReq = 1'b0;
      @(posedge CLK); #1;
      check("err_clear", MemErr, 0);
      check("err_rd_kept", MemRD, exp_rd);
    end else begin
      check("acc_req", dm_req, 1);
      check("acc_we", dm_we, we);
      check("acc_be", dm_be, ebe);
      check("acc_addr", dm_addr, a[11:2]);
      if (we) check("acc_wdata", dm_wdata, ewd);
      while (Stall && cyc < 100) begin
        cyc++;
        @(posedge CLK); #1;
      end
      check("acc_cycles", cyc, dly + 1);
      if (we) begin
        for (int k = 0; k < n; k++) ref_mem[int'(a[11:0]) + k] = wd[8*k +: 8];
      end else begin
        exp_rd = model_load(sz, a);
      end
      check("done_rd", MemRD, exp_rd);
      check("done_req_low", dm_req, 0);
      check("done_no_err", MemErr, 0);
      @(negedge CLK); MemReq = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm_mem[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = dm_mem[i][8*k +: 8];
    end

    #1;
    check("rst_rd", MemRD, 0);
    check("rst_err", MemErr, 0);
    check("rst_req", dm_req, 0);
    check("rst_we", dm_we, 0);
    check("rst_be", dm_be, 0);
    check("rst_addr", dm_addr, 0);
    check("rst_wdata", dm_wdata, 0);
    check("rst_stall", Stall, 0);
    @(negedge CLK); RESET = 1'b1;

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0);
    check("lw_deadbeef", MemRD, 32'hDEADBEEF);
    access(1'b1, 3'b000, 32'h13, 32'h000000A5, 0);
    access(1'b0, 3'b000, 32'h13, 32'h0, 1);
    check("lb_a5", MemRD, 32'hFFFFFFA5);
    access(1'b0, 3'b100, 32'h13, 32'h0, 2);
    check("lbu_a5", MemRD, 32'h000000A5);
    access(1'b1, 3'b010, 32'h10, 32'h80011234, 0);
    access(1'b0, 3'b001, 32'h12, 32'h0, 0);
    check("lh_8001", MemRD, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h12, 32'h0, 0);
    check("lhu_8001", MemRD, 32'h00008001);
    access(1'b0, 3'b001, 32'h11, 32'h0, 0);
    access(1'b0, 3'b011, 32'h10, 32'h0, 0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 5);

    // Reset in the middle of an access that is never acknowledged.
    ack_delay = 1000;
    @(negedge CLK);
    MemReq = 1'b1; MemWE = 1'b0; MemSize = 3'b010; MemA = 32'h20;
    @(posedge CLK); #1;
    check("rst_mid_req_up", dm_req, 1);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("rst_mid_req_drop", dm_req, 0);
    check("rst_mid_be", dm_be, 0);
    check("rst_mid_rd", MemRD, 0);
    exp_rd = '0;
    MemReq = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    access(1'b0, 3'b010, 32'h10, 32'h0, 1);
    check("lw_after_rst", MemRD, 32'h80011234);

`ifdef LSU_TIMEOUT_EN
    begin
      int cyc = 0;
      ack_delay = 1000;
      @(negedge CLK);
      MemReq = 1'b1; MemWE = 1'b0; MemSize = 3'b010; MemA = 32'h30;
      @(posedge CLK); #1;
      while (Stall && cyc < 100) begin
        cyc++;
        @(posedge CLK); #1;
      end
      check("tmo_cycles", cyc, 16);
      check("tmo_err", MemErr, 1);
      check("tmo_req_drop", dm_req, 0);
      @(negedge CLK); MemReq = 1'b0;
      @(posedge CLK); #1;
      check("tmo_err_clear", MemErr, 0);
      check("tmo_rd_kept", MemRD, exp_rd);
    end
`endif

    for (int t = 0; t < 80; t++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      int          pick = $urandom_range(0, 11);
      case (pick)
        0, 8:  sz = 3'b000;
        1, 9:  sz = 3'b001;
        2, 10: sz = 3'b010;
        3:     sz = 3'b100;
        4, 11: sz = 3'b101;
        5:     sz = 3'b011;
        6:     sz = 3'b110;
        default: sz = 3'b111;
      endcase
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      access(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
